// File: rtl/alu_sel_pkg.sv
// Shared types and constants for the registered ALU result selector.
package alu_sel_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

  localparam int ZERO_B  = 0;
  localparam int NEG_B   = 1;
  localparam int ILL_B   = 2;
  localparam int MAX_OPS = 16;
endpackage

// File: rtl/alu_sel_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready is registered so it never
// depends combinationally on out_ready.
module alu_sel_skid_buf
  import alu_sel_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q;
  logic         accept, pop;

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign accept    = in_valid & rdy_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        head_d  = in_data;
      end
      ONE: begin
        if (accept && pop) begin
          head_d = in_data;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: if (pop) begin
        state_d = ONE;
        head_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != TWO);
    end
  end

endmodule

// File: rtl/alu_result_sel_pipe.sv
// Selects one ALU candidate, tags it with Zero/Negative/IllegalOp and hands it
// to writeback through a skid buffer; also counts accepts and latches errors.
module alu_result_sel_pipe
  import alu_sel_pkg::*;
#(
  parameter int N       = 4,
  parameter int NUM_OPS = 10,
  parameter int SEL_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_OPS-1:0][N-1:0]   I,
  input  logic [SEL_W-1:0]            ALUControl,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N-1:0]                Result,
  output logic                        Zero,
  output logic                        Negative,
  output logic                        IllegalOp,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        err_sticky,
  input  logic                        err_clr,
  output logic [CNT_W-1:0]            op_count
);

  localparam int PW = N + 3;

  logic [N-1:0]     sel;
  logic             ill;
  logic [2:0]       flags;
  logic [PW-1:0]    pl_in, pl_out;
  logic             accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Out-of-range codes select zero, so the entry still carries a defined value.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_OPS; k++)
      if (ALUControl == SEL_W'(k)) sel = I[k];
  end

  assign ill = (32'(ALUControl) >= 32'(NUM_OPS));

  always_comb begin
    flags         = '0;
    flags[ZERO_B] = (sel == '0);
    flags[NEG_B]  = sel[N-1];
    flags[ILL_B]  = ill;
  end

  assign pl_in  = {flags, sel};
  assign accept = in_valid & in_ready;

  alu_sel_skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pl_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pl_out)
  );

  assign Result    = pl_out[N-1:0];
  assign Zero      = pl_out[N+ZERO_B];
  assign Negative  = pl_out[N+NEG_B];
  assign IllegalOp = pl_out[N+ILL_B];

  always_comb begin
    cnt_d = accept ? cnt_q + CNT_W'(1) : cnt_q;
    // A coincident illegal accept outranks the clear.
    err_d = err_q;
    if (accept && ill) err_d = 1'b1;
    else if (err_clr)  err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign op_count   = cnt_q;
  assign err_sticky = err_q;

endmodule
